// File: rtl/counter_pkg.sv
// Shared constants and helpers for the counter family: direction/mode encodings
// and the prescaler width helper.
package counter_pkg;

   localparam logic DIR_DOWN     = 1'b0;
   localparam logic DIR_UP       = 1'b1;
   localparam logic MODE_WRAP    = 1'b0;
   localparam logic MODE_ONESHOT = 1'b1;

   // Width of a counter holding 0..n-1; never narrower than one bit.
   function automatic int presc_width(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/mod_counter_prescale.sv
// Step-enable strobe generator: counts enabled cycles 0..PRESCALE-1 and fires
// step on the last one. clr zeroes the count and wins over cnt_en.
module mod_counter_prescale
   import counter_pkg::*;
#(
   parameter int PRESCALE = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic cnt_en,
   input  logic clr,
   output logic step
);

   localparam int PW = presc_width(PRESCALE);
   localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

   logic [PW-1:0] cnt;

   assign step = cnt_en && !clr && (cnt == LAST);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (cnt_en) begin
         cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
      end
   end

endmodule

// File: rtl/mod_counter.sv
// Modulo up/down counter with load, one-shot mode, terminal-count pulse and
// sticky wrap flag. Define MOD_COUNTER_PRESCALE_EN to compile in the prescaler.
module mod_counter
   import counter_pkg::*;
#(
   parameter int WIDTH     = 4,
   parameter int MAX_COUNT = 2**WIDTH - 1,
   parameter int PRESCALE  = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic             dir,
   input  logic             mode,
   input  logic             clr,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] q,
   output logic             tc,
   output logic             done,
   output logic             ovf
);

   localparam logic [WIDTH-1:0] MAXV = WIDTH'(MAX_COUNT);
   // An illegal parameter set never steps, so it is visible at the first test.
   localparam logic CFG_OK = (WIDTH >= 1) && (PRESCALE >= 1) && (MAX_COUNT >= 0) &&
                             (longint'(MAX_COUNT) <= ((longint'(1) << WIDTH) - 1));

   logic             step;
   logic             at_term;
   logic             lands;
   logic [WIDTH-1:0] q_next;
   logic [WIDTH-1:0] load_clamped;

`ifdef MOD_COUNTER_PRESCALE_EN
   mod_counter_prescale #(
      .PRESCALE (PRESCALE)
   ) u_prescale (
      .clk    (clk),
      .reset  (reset),
      .cnt_en (en && !done && CFG_OK),
      .clr    (clr || load),
      .step   (step)
   );
`else
   assign step = en && !done && CFG_OK;
`endif

   always_comb begin
      load_clamped = (load_val > MAXV) ? MAXV : load_val;
      q_next       = (dir == DIR_UP) ? q + 1'b1 : q - 1'b1;
      at_term      = (dir == DIR_UP) ? (q == MAXV) : (q == '0);
      lands        = (dir == DIR_UP) ? (q_next == MAXV) : (q_next == '0);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         q    <= '0;
         tc   <= 1'b0;
         done <= 1'b0;
         ovf  <= 1'b0;
      end else if (clr) begin
         q    <= '0;
         tc   <= 1'b0;
         done <= 1'b0;
         ovf  <= 1'b0;
      end else if (load) begin
         q    <= load_clamped;
         tc   <= 1'b0;
         done <= 1'b0;
      end else begin
         tc <= 1'b0;
         if (step) begin
            if (!at_term) begin
               q <= q_next;
               if (mode == MODE_ONESHOT && lands) begin
                  done <= 1'b1;
                  tc   <= 1'b1;
               end
            end else if (mode == MODE_WRAP) begin
               q   <= (dir == DIR_UP) ? '0 : MAXV;
               tc  <= 1'b1;
               ovf <= 1'b1;
            end else begin
               // One-shot already sitting on terminal (e.g. just loaded): finish in place.
               done <= 1'b1;
               tc   <= 1'b1;
            end
         end
      end
   end

endmodule
